mem_sram_axi_slave_banked: RTL

Parametrised banked on-chip SRAM behind the simplified AXI slave interface used on the core memory bus. It has N banks and a configurable data width, read latency and base address. Reads and writes share one SRAM port under round-robin arbitration. Byte/half/word/dword accesses use lane strobes, and illegal accesses return an error response. It replaces the fixed 8x8KiB SRAM slave and sits on the system bus as the main RAM target.

---
 rtl/mem_sram_pkg.sv | 42 ++++
 rtl/mem_sram_bank.sv | 33 +++
 rtl/mem_sram_axi_slave_banked.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_pkg.sv
// Shared encodings and helpers for the banked SRAM bus slave.
package mem_sram_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRdResp,
    StWrResp
  } state_e;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SZ_BYTE: mask = 3'b000;
      SZ_HALF: mask = 3'b001;
      SZ_WORD: mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] ones;
    case (size)
      SZ_BYTE: ones = 8'h01;
      SZ_HALF: ones = 8'h03;
      SZ_WORD: ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << lane;
  endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// Single SRAM bank with byte-enable writes and a RD_LAT-deep read pipeline.
module mem_sram_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                en,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout
);

  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [DATA_W-1:0] pipe_q [RD_LAT];

  // Later stages shift freely; they settle on the last read and hold it until the next one.
  always_ff @(posedge clk) begin
    if (en && wen) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= din[8*b +: 8];
      end
    end
    if (en && !wen) pipe_q[0] <= mem_q[addr];
    for (int s = 1; s < RD_LAT; s++) pipe_q[s] <= pipe_q[s-1];
  end

  assign dout = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mem_sram_axi_slave_banked.sv
// Banked on-chip SRAM behind the simplified AXI slave port; one transaction at a time,
// round-robin between read and write requests.
module mem_sram_axi_slave_banked #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       BANK_NUM   = 8,
  parameter int unsigned       BANK_BYTES = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [1:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [1:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  import mem_sram_pkg::*;

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned LaneW = $clog2(Bytes);
  localparam int unsigned Depth = BANK_BYTES / Bytes;
  localparam int unsigned RowW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned BankW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int unsigned OffW  = $clog2(BANK_BYTES);
  localparam logic [63:0] Span  = 64'(BANK_NUM) * 64'(BANK_BYTES);

  state_e            state_q;
  logic              rd_prio_q;
  logic              rvalid_q, bvalid_q;
  logic [1:0]        rresp_q, bresp_q;
  logic              issue_q, is_wr_q;
  logic [BankW-1:0]  bank_q;
  logic [RowW-1:0]   row_q;
  logic [Bytes-1:0]  be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        cnt_q;

  logic              idle, rd_req, wr_req, grant_rd, grant_wr;
  logic [ADDR_W-1:0] sel_addr, off;
  logic [1:0]        sel_size;
  logic              dec_err;
  logic [BankW-1:0]  dec_bank;
  logic [RowW-1:0]   dec_row;
  logic [Bytes-1:0]  dec_be;

  // Readies are combinational in IDLE and forced low while reset is held.
  assign idle     = (state_q == StIdle) && rst_n;
  assign rd_req   = arvalid;
  assign wr_req   = awvalid && wvalid;
  assign grant_rd = idle && rd_req && (!wr_req || rd_prio_q);
  assign grant_wr = idle && wr_req && (!rd_req || !rd_prio_q);

  assign arready = grant_rd;
  assign awready = grant_wr;
  assign wready  = grant_wr;

  always_comb begin
    sel_addr = grant_rd ? araddr : awaddr;
    sel_size = grant_rd ? arsize : awsize;
    off      = sel_addr - BASE_ADDR;
    dec_bank = BankW'(off >> OffW);
    dec_row  = RowW'((off & ADDR_W'(BANK_BYTES - 1)) >> LaneW);
    dec_be   = Bytes'(byte_en(sel_size, 3'(sel_addr & ADDR_W'(Bytes - 1))));
    dec_err  = (sel_addr < BASE_ADDR) ||
               (64'(off) >= Span) ||
               (|(3'(sel_addr) & size_mask(sel_size))) ||
               ((sel_size == SZ_DWORD) && (DATA_W == 32));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_prio_q <= 1'b1;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
      issue_q   <= 1'b0;
      is_wr_q   <= 1'b0;
      bank_q    <= '0;
      row_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      issue_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_rd) begin
            rd_prio_q <= 1'b0;
            is_wr_q   <= 1'b0;
            bank_q    <= dec_bank;
            row_q     <= dec_row;
            if (dec_err) begin
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              state_q  <= StRdResp;
            end else begin
              issue_q <= 1'b1;
              rresp_q <= RESP_OKAY;
              cnt_q   <= 2'(RD_LAT - 1);
              state_q <= StRdWait;
            end
          end else if (grant_wr) begin
            rd_prio_q <= 1'b1;
            is_wr_q   <= 1'b1;
            bank_q    <= dec_bank;
            row_q     <= dec_row;
            be_q      <= dec_be;
            wdata_q   <= wdata;
            issue_q   <= !dec_err;
            bvalid_q  <= 1'b1;
            bresp_q   <= dec_err ? RESP_SLVERR : RESP_OKAY;
            state_q   <= StWrResp;
          end
        end
        StRdWait: begin
          if (cnt_q == 2'd0) begin
            rvalid_q <= 1'b1;
            state_q  <= StRdResp;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StRdResp: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StWrResp: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [DATA_W-1:0] bank_dout [BANK_NUM];

  for (genvar i = 0; i < BANK_NUM; i++) begin : g_bank
    mem_sram_bank #(
      .DATA_W(DATA_W),
      .DEPTH (Depth),
      .RD_LAT(RD_LAT)
    ) u_bank (
      .clk (clk),
      .en  (issue_q && (bank_q == BankW'(i))),
      .wen (is_wr_q),
      .be  (be_q),
      .addr(row_q),
      .din (wdata_q),
      .dout(bank_dout[i])
    );
  end

  // The selected bank holds its last read word, so rdata stays stable through a stall.
  assign rdata  = (rvalid_q && (rresp_q == RESP_OKAY)) ? bank_dout[bank_q] : '0;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

endmodule
